pipelined_rca: RTL and testbench
================================

// Module: pipelined_rca
// PURPOSE
//  Parametrised, pipelined ripple-carry add/subtract unit; successor to the fixed 64-bit registered RCA.
//  Splits a WIDTH-bit ripple chain into STAGES equal segments with carry and operand-skew registers
//  between them, adds a valid/ready handshake with backpressure, a subtract mode and a signed overflow flag.
//  Sits in the adder-comparison datapath as the throughput-oriented RCA variant.
// PARAMETERS
//  WIDTH   64  operand/sum width in bits; WIDTH >= 2
//  STAGES  4   number of ripple segments / pipeline stages; 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      synchronous, active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  a_in       in   WIDTH  operand A
//  b_in       in   WIDTH  operand B
//  cin_in     in   1      carry-in (ignored when sub_in=1)
//  sub_in     in   1      0: A+B+cin  1: A-B (A + ~B + 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum_out    out  WIDTH  result
//  cout_out   out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf_out    out  1      signed overflow = carry-into-MSB XOR carry-out-of-MSB
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-low: sampled only on posedge clk while reset_n=0.
//  - Reset: out_valid=0, sum_out=0, cout_out=0, ovf_out=0, all stage valids and data registers cleared.
//    in_ready=1 in the first cycle after reset_n returns high.
//  - Pipeline: input register stage (A, B, cin, sub), then STAGES segment stages of SEG=WIDTH/STAGES bits.
//    Segment k ripples bits [k*SEG +: SEG] with carry from segment k-1's register; bits above the current
//    segment are carried forward unmodified (skew); completed lower sum bits are carried forward (deskew).
//  - Latency: beat accepted at edge N -> out_valid=1 with its result after edge N+STAGES+1 (no stalls).
//  - Throughput: one beat per cycle when out_ready=1.
//  - Handshake: global enable en = !out_valid | out_ready; in_ready = en. Beat transfers on in_valid&in_ready;
//    result transfers on out_valid&out_ready. When en=0 every pipeline register holds (no bubble collapse).
//    out_valid, sum_out, cout_out, ovf_out stable while out_valid=1 and out_ready=0.
//  - in_ready is combinational from out_valid/out_ready only; no path from in_valid to in_ready.
//  - Bubbles: in_valid=0 with en=1 inserts a stage valid=0; data regs may load don't-care but out_valid=0.
//  - Subtract: operand B inverted and carry-in forced 1 at the input register; cin_in ignored.
//  - Arithmetic is modulo 2^WIDTH; cout_out is bit WIDTH of the full sum; ovf_out per PORTS.
//  - STAGES=1: single segment, latency 2; behaviour identical to the fixed registered RCA plus handshake.
//  - Reset mid-operation: all in-flight beats discarded; no result for them is ever presented.
//  - Simultaneous accept and emit with out_ready=1: both happen in the same cycle; occupancy unchanged.
//  - Elaboration: illegal WIDTH/STAGES combination must fail elaboration (generate-time $error).
// TESTING
//  1. W=64,S=4: A=all-ones, B=0, cin=1, sub=0 -> sum=0, cout=1, ovf=0 after exactly 5 cycles.
//  2. W=64,S=4: A=5, B=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0.
//  3. W=64,S=4: A=0x7FFF_FFFF_FFFF_FFFF, B=1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1;
//     A=0x8000_0000_0000_0000, B=1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
//  4. Stream 20 random beats back-to-back, out_ready toggled pseudo-randomly -> all 20 results in order,
//     match reference model, no drop/duplicate, outputs stable while stalled, in_ready=0 only when stalled.
//  5. Drive 3 beats, assert reset_n=0 for one cycle mid-flight -> next cycle out_valid=0, outputs 0,
//     none of the 3 results ever appears; fresh beat after reset returns correct sum at latency S+1.
//  6. Re-run 1-4 with W=8,S=1 and W=16,S=16 -> latency 2 and 17 respectively, results correct.

Source files
------------

// File: rtl/pipelined_rca.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_rca
// Purpose  : Pipelined ripple-carry add/subtract unit. A WIDTH-bit ripple
//            chain is split into STAGES equal segments with carry and operand
//            skew registers between them. Valid/ready handshake with global
//            stall, subtract mode and signed overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_rca #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out
);

  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_rca: illegal WIDTH/STAGES combination");
  end

  // Global enable: the whole pipe advances together or holds together.
  logic en;

  // Stage 0 is the input register; stage k+1 holds the result of segment k.
  // The a register doubles as the sum register: bits below the segment just
  // rippled carry finished sum bits, bits at or above it still carry operand A.
  logic [STAGES:0]    v_q, v_d;
  logic [WIDTH-1:0]   a_q [STAGES+1];
  logic [WIDTH-1:0]   a_d [STAGES+1];
  logic [WIDTH-1:0]   b_q [STAGES];
  logic [WIDTH-1:0]   b_d [STAGES];
  logic [STAGES:0]    c_q, c_d;
  logic               cm_q, cm_d;     // carry into the MSB, aligned with stage STAGES

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SEG-1:0]     seg_s [STAGES];
  logic [STAGES-1:0]  seg_c;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    logic [SEG-1:0] s;
    logic           co;

    // Ripple this segment's bits starting from the carry registered upstream.
    always_comb begin
      logic cy;
      cy = c_q[k];
      s  = '0;
      for (int j = 0; j < SEG; j++) begin
        s[j] = a_q[k][k*SEG+j] ^ b_q[k][k*SEG+j] ^ cy;
        cy   = (a_q[k][k*SEG+j] & b_q[k][k*SEG+j])
             | (cy & (a_q[k][k*SEG+j] ^ b_q[k][k*SEG+j]));
      end
      co = cy;
    end

    assign seg_s[k] = s;
    assign seg_c[k] = co;
  end

  // Next-state for every pipeline register; everything holds while stalled.
  always_comb begin
    en          = !out_valid_q || out_ready;
    v_d         = v_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    cm_d        = cm_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (en) begin
      // Subtract is A + ~B + 1, folded in before the first segment.
      v_d[0] = in_valid;
      a_d[0] = a_in;
      b_d[0] = sub_in ? ~b_in : b_in;
      c_d[0] = sub_in | cin_in;
      for (int k = 0; k < STAGES; k++) begin
        v_d[k+1]                = v_q[k];
        a_d[k+1]                = a_q[k];
        a_d[k+1][k*SEG +: SEG]  = seg_s[k];
        c_d[k+1]                = seg_c[k];
      end
      for (int k = 1; k < STAGES; k++) begin
        b_d[k] = b_q[k-1];
      end
      // Carry into the MSB recovered from the MSB sum bit and its operands.
      cm_d        = seg_s[STAGES-1][SEG-1] ^ a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1];
      out_valid_d = v_q[STAGES];
      sum_d       = a_q[STAGES];
      cout_d      = c_q[STAGES];
      ovf_d       = cm_q ^ c_q[STAGES];
    end
  end

  // Pipeline registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q         <= '0;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
      c_q         <= '0;
      cm_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      v_q         <= v_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      cm_q        <= cm_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;
  assign cout_out  = cout_q;
  assign ovf_out   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_rca.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_rca
// Purpose  : Self-checking bench for pipelined_rca; three configurations
//            (64/4, 8/1, 16/16) share one stimulus stream and are compared
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_rca;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, cin_in, sub_in, out_ready;
  logic [63:0] a_in, b_in;
  logic [2:0]  in_ready, out_valid, cout, ovf;
  logic [63:0] sum0;
  logic [7:0]  sum1;
  logic [15:0] sum2;
  logic [63:0] sumx [3];

  assign sumx[0] = sum0;
  assign sumx[1] = {56'd0, sum1};
  assign sumx[2] = {48'd0, sum2};

  pipelined_rca #(.WIDTH(64), .STAGES(4)) u_w64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in), .sub_in(sub_in),
    .out_valid(out_valid[0]), .out_ready(out_ready), .sum_out(sum0),
    .cout_out(cout[0]), .ovf_out(ovf[0]));

  pipelined_rca #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a_in(a_in[7:0]), .b_in(b_in[7:0]), .cin_in(cin_in), .sub_in(sub_in),
    .out_valid(out_valid[1]), .out_ready(out_ready), .sum_out(sum1),
    .cout_out(cout[1]), .ovf_out(ovf[1]));

  pipelined_rca #(.WIDTH(16), .STAGES(16)) u_w16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a_in(a_in[15:0]), .b_in(b_in[15:0]), .cin_in(cin_in), .sub_in(sub_in),
    .out_valid(out_valid[2]), .out_ready(out_ready), .sum_out(sum2),
    .cout_out(cout[2]), .ovf_out(ovf[2]));

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [2:0]  last_acc;
  logic [65:0] q0 [$];
  logic [65:0] q1 [$];
  logic [65:0] q2 [$];

  function automatic int wid(int k);
    return (k == 0) ? 64 : (k == 1) ? 8 : 16;
  endfunction

  function automatic int lat(int k);
    return (k == 0) ? 5 : (k == 1) ? 2 : 17;
  endfunction

  // Reference: {ovf, cout, sum} from plain modular arithmetic on w bits.
  function automatic logic [65:0] model(int w, logic [63:0] a, logic [63:0] b,
                                        logic cin, logic sub);
    logic [64:0] mask, am, bm, full;
    logic        sa, sbe, ss, ov;
    mask = (65'd1 << w) - 65'd1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    if (sub) full = am + ((~bm) & mask) + 65'd1;
    else     full = am + bm + {64'd0, cin};
    sa  = am[w-1];
    sbe = sub ? ~bm[w-1] : bm[w-1];
    ss  = full[w-1];
    ov  = (sa == sbe) && (ss != sa);
    return {ov, full[w], full[63:0] & mask[63:0]};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(int k, logic [65:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(int k, output logic [65:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    case (k)
      0:       if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int sb_size(int k);
    return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
  endfunction

  // One clock: scoreboard transfers before the edge, stall stability after.
  task automatic tick();
    logic [2:0]  emt, stl;
    logic [63:0] hs [3];
    logic [2:0]  hc, ho;
    logic [65:0] e;
    bit          ok;
    #1;
    for (int k = 0; k < 3; k++) begin
      last_acc[k] = reset_n & in_valid & in_ready[k];
      emt[k]      = reset_n & out_valid[k] & out_ready;
      stl[k]      = reset_n & out_valid[k] & ~out_ready;
      hs[k] = sumx[k]; hc[k] = cout[k]; ho[k] = ovf[k];
      check($sformatf("in_ready[%0d]", k), {63'd0, in_ready[k]},
            {63'd0, !(out_valid[k] && !out_ready)});
      if (emt[k]) begin
        sb_pop(k, e, ok);
        if (!ok) check($sformatf("unexpected_result[%0d]", k), 64'd1, 64'd0);
        else begin
          check($sformatf("sum[%0d]", k),  sumx[k], e[63:0]);
          check($sformatf("cout[%0d]", k), {63'd0, cout[k]}, {63'd0, e[64]});
          check($sformatf("ovf[%0d]", k),  {63'd0, ovf[k]},  {63'd0, e[65]});
        end
      end
      if (last_acc[k]) sb_push(k, model(wid(k), a_in, b_in, cin_in, sub_in));
    end
    @(posedge clk);
    #1;
    if (!reset_n) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (stl[k]) begin
          check($sformatf("stall_valid[%0d]", k), {63'd0, out_valid[k]}, 64'd1);
          check($sformatf("stall_sum[%0d]", k),   sumx[k], hs[k]);
          check($sformatf("stall_cout[%0d]", k),  {63'd0, cout[k]}, {63'd0, hc[k]});
          check($sformatf("stall_ovf[%0d]", k),   {63'd0, ovf[k]},  {63'd0, ho[k]});
        end
      end
    end
  endtask

  // Single beat into an empty pipe; measures first-valid latency per config
  // and checks the 64-bit result against the given constants.
  task automatic lat_test(logic [63:0] a, logic [63:0] b, logic cin, logic sub,
                          logic [63:0] es, logic ec, logic eo);
    bit seen [3];
    seen = '{default: 1'b0};
    out_ready = 1'b1; in_valid = 1'b1;
    a_in = a; b_in = b; cin_in = cin; sub_in = sub;
    tick();
    in_valid = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && !seen[k]) begin
          seen[k] = 1'b1;
          check($sformatf("latency[%0d]", k), 64'(j), 64'(lat(k)));
          if (k == 0) begin
            check("const_sum",  sum0, es);
            check("const_cout", {63'd0, cout[0]}, {63'd0, ec});
            check("const_ovf",  {63'd0, ovf[0]},  {63'd0, eo});
          end
        end
      end
    end
    for (int k = 0; k < 3; k++)
      if (!seen[k]) check($sformatf("latency_timeout[%0d]", k), 64'd0, 64'(lat(k)));
  endtask

  initial begin
    int n_sent;
    reset_n = 1'b0; in_valid = 1'b0; cin_in = 1'b0; sub_in = 1'b0;
    out_ready = 1'b1; a_in = '0; b_in = '0; last_acc = '0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid[%0d]", k), {63'd0, out_valid[k]}, 64'd0);
      check($sformatf("rst_sum[%0d]", k),   sumx[k], 64'd0);
      check($sformatf("rst_cout[%0d]", k),  {63'd0, cout[k]}, 64'd0);
      check($sformatf("rst_ovf[%0d]", k),   {63'd0, ovf[k]},  64'd0);
    end
    reset_n = 1'b1;
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("rst_in_ready[%0d]", k), {63'd0, in_ready[k]}, 64'd1);

    // Directed arithmetic corners.
    lat_test(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    lat_test(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    lat_test(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    lat_test(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Random back-to-back stream with random backpressure.
    n_sent = 0;
    for (int c = 0; c < 3000; c++) begin
      if (n_sent >= 20 && q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      in_valid  = (n_sent < 20);
      a_in      = {$urandom, $urandom};
      b_in      = {$urandom, $urandom};
      cin_in    = 1'($urandom);
      sub_in    = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (last_acc[0]) n_sent++;
    end
    in_valid = 1'b0;
    check("stream_sent", 64'(n_sent), 64'd20);
    for (int k = 0; k < 3; k++)
      check($sformatf("stream_pending[%0d]", k), 64'(sb_size(k)), 64'd0);

    // Reset with beats in flight: none of them may ever surface.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
      cin_in = 1'($urandom); sub_in = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midrst_valid[%0d]", k), {63'd0, out_valid[k]}, 64'd0);
      check($sformatf("midrst_sum[%0d]", k),   sumx[k], 64'd0);
      check($sformatf("midrst_cout[%0d]", k),  {63'd0, cout[k]}, 64'd0);
      check($sformatf("midrst_ovf[%0d]", k),   {63'd0, ovf[k]},  64'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    lat_test(64'd3, 64'd4, 1'b1, 1'b0, 64'd8, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      check($sformatf("final_pending[%0d]", k), 64'(sb_size(k)), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
